// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel editor for the preset time loaded into the
// 12 h / 24 h clocks. It walks IDLE -> HRS -> MIN -> SEC -> COMMIT on the set
// button and steps the selected field with inc/dec, including auto-repeat.
// It also aborts an edit after an idle timeout and drives the blink status
// for the VGA overlay.
module time_set_ctrl #(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 10000,
  parameter int BLINK_HALF   = 250
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_set_i,
  input  logic       btn_inc_i,
  input  logic       btn_dec_i,
  input  logic [4:0] cur_hrs_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic [4:0] set_hrs_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       load_o,
  output logic       editing_o,
  output logic [1:0] field_o,
  output logic       blink_o
);

  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int BLNK_W = $clog2(BLINK_HALF + 1);

  localparam logic [5:0] HRS_MAX = 6'd23;
  localparam logic [5:0] MS_MAX  = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HRS,
    ST_MIN,
    ST_SEC,
    ST_COMMIT
  } state_t;

  state_t state;

  logic set_p0, set_p1;
  logic inc_p0, inc_p1;
  logic dec_p0, dec_p1;

  logic [HOLD_W-1:0] hold_cnt;
  logic [RATE_W-1:0] rate_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [BLNK_W-1:0] blink_cnt;

  logic set_rise, inc_rise, dec_rise;
  logic in_edit, one_held, any_act, auto_fire, do_step, timed_out;

  // Wrap-around step; values above max (possible from a raw capture) are
  // normalised by the first step in either direction.
  function automatic logic [5:0] step_field(input logic [5:0] v,
                                            input logic [5:0] mx,
                                            input logic       up);
    logic [5:0] r;
    if (up) r = (v >= mx) ? 6'd0 : v + 6'd1;
    else    r = ((v == 6'd0) || (v > mx)) ? mx : v - 6'd1;
    return r;
  endfunction

  // Register each button once; the previous sample gives the rising edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      set_p0 <= 1'b0; set_p1 <= 1'b0;
      inc_p0 <= 1'b0; inc_p1 <= 1'b0;
      dec_p0 <= 1'b0; dec_p1 <= 1'b0;
    end else begin
      set_p0 <= btn_set_i; set_p1 <= set_p0;
      inc_p0 <= btn_inc_i; inc_p1 <= inc_p0;
      dec_p0 <= btn_dec_i; dec_p1 <= dec_p0;
    end
  end

  // Edge, hold and step decode from the registered button levels.
  always_comb begin
    set_rise  = set_p0 & ~set_p1;
    inc_rise  = inc_p0 & ~inc_p1;
    dec_rise  = dec_p0 & ~dec_p1;
    in_edit   = (state == ST_HRS) || (state == ST_MIN) || (state == ST_SEC);
    one_held  = inc_p0 ^ dec_p0;
    any_act   = set_p0 | inc_p0 | dec_p0;
    auto_fire = (hold_cnt == HOLD_W'(REPEAT_DELAY)) && (rate_cnt == '0);
    // A set rise wins over any step; both buttons together never step.
    do_step   = in_edit && !set_rise && one_held &&
                (inc_rise || dec_rise || auto_fire);
    timed_out = in_edit && !any_act && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  end

  // Hold counter saturates at the repeat delay, then the rate counter paces
  // further repeats; inactivity counter tracks idle cycles while editing.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_cnt <= '0;
      rate_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      if (!in_edit || !one_held || set_rise) begin
        hold_cnt <= '0;
        rate_cnt <= '0;
      end else if (hold_cnt != HOLD_W'(REPEAT_DELAY)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        rate_cnt <= (rate_cnt == RATE_W'(REPEAT_RATE - 1)) ? '0 : rate_cnt + 1'b1;
      end
      if (!in_edit || any_act) idle_cnt <= '0;
      else                     idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Edit state machine with registered outputs and shadow time registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      set_hrs_o <= '0;
      set_min_o <= '0;
      set_sec_o <= '0;
      load_o    <= 1'b0;
      editing_o <= 1'b0;
      field_o   <= 2'd0;
      blink_o   <= 1'b0;
      blink_cnt <= '0;
    end else begin
      load_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          blink_cnt <= '0;
          if (set_rise) begin
            set_hrs_o <= cur_hrs_i;
            set_min_o <= cur_min_i;
            set_sec_o <= cur_sec_i;
            state     <= ST_HRS;
            editing_o <= 1'b1;
            field_o   <= 2'd1;
            blink_o   <= 1'b1;
          end
        end
        ST_HRS, ST_MIN, ST_SEC: begin
          if (set_rise) begin
            blink_o   <= 1'b1;
            blink_cnt <= '0;
            if (state == ST_HRS) begin
              state   <= ST_MIN;
              field_o <= 2'd2;
            end else if (state == ST_MIN) begin
              state   <= ST_SEC;
              field_o <= 2'd3;
            end else begin
              state     <= ST_COMMIT;
              load_o    <= 1'b1;
              editing_o <= 1'b0;
              field_o   <= 2'd0;
              blink_o   <= 1'b0;
            end
          end else if (timed_out) begin
            state     <= ST_IDLE;
            editing_o <= 1'b0;
            field_o   <= 2'd0;
            blink_o   <= 1'b0;
            blink_cnt <= '0;
          end else if (do_step) begin
            blink_o   <= 1'b1;
            blink_cnt <= '0;
            if (state == ST_HRS)
              set_hrs_o <= 5'(step_field({1'b0, set_hrs_o}, HRS_MAX, inc_p0));
            else if (state == ST_MIN)
              set_min_o <= step_field(set_min_o, MS_MAX, inc_p0);
            else
              set_sec_o <= step_field(set_sec_o, MS_MAX, inc_p0);
          end else if (blink_cnt == BLNK_W'(BLINK_HALF - 1)) begin
            blink_o   <= ~blink_o;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          editing_o <= 1'b0;
          field_o   <= 2'd0;
          blink_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed button sequences; expected snapshots
// and expected load values are queued by the stimulus and checked by monitors.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       btn_set_i, btn_inc_i, btn_dec_i;
  logic [4:0] cur_hrs_i;
  logic [5:0] cur_min_i, cur_sec_i;
  logic [4:0] set_hrs_o;
  logic [5:0] set_min_o, set_sec_o;
  logic       load_o, editing_o, blink_o;
  logic [1:0] field_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       ed;
    logic [1:0] fld;
    logic       bl;
    logic       bl_care;
    logic       ld;
  } snap_t;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } load_t;

  snap_t snap_q[$];
  load_t load_q[$];

  always #5 clk = ~clk;

  time_set_ctrl dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .btn_set_i (btn_set_i),
    .btn_inc_i (btn_inc_i),
    .btn_dec_i (btn_dec_i),
    .cur_hrs_i (cur_hrs_i),
    .cur_min_i (cur_min_i),
    .cur_sec_i (cur_sec_i),
    .set_hrs_o (set_hrs_o),
    .set_min_o (set_min_o),
    .set_sec_o (set_sec_o),
    .load_o    (load_o),
    .editing_o (editing_o),
    .field_o   (field_o),
    .blink_o   (blink_o)
  );

  // Snapshot monitor: compares every queued expectation at the falling edge.
  always @(negedge clk) begin
    snap_t e;
    logic  ok;
    while (snap_q.size() > 0) begin
      e  = snap_q.pop_front();
      ok = (set_hrs_o == e.h) && (set_min_o == e.m) && (set_sec_o == e.s) &&
           (editing_o == e.ed) && (field_o == e.fld) && (load_o == e.ld) &&
           (!e.bl_care || (blink_o == e.bl));
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s got=%0d:%0d:%0d ed=%0d fld=%0d bl=%0d ld=%0d exp=%0d:%0d:%0d ed=%0d fld=%0d bl=%0d(care=%0d) ld=%0d",
                 e.name, set_hrs_o, set_min_o, set_sec_o, editing_o, field_o, blink_o, load_o,
                 e.h, e.m, e.s, e.ed, e.fld, e.bl, e.bl_care, e.ld);
      end
    end
  end

  // Load monitor: every load pulse must match the next queued commit value.
  always @(negedge clk) begin
    load_t l;
    if (load_o) begin
      total++;
      if (load_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_load got=%0d:%0d:%0d exp=no load", set_hrs_o, set_min_o, set_sec_o);
      end else begin
        l = load_q.pop_front();
        if ((set_hrs_o != l.h) || (set_min_o != l.m) || (set_sec_o != l.s)) begin
          bad++;
          $display("FAIL load_value got=%0d:%0d:%0d exp=%0d:%0d:%0d",
                   set_hrs_o, set_min_o, set_sec_o, l.h, l.m, l.s);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One-cycle button pulse; returns once the resulting update has happened.
  task automatic press(input bit s, input bit i, input bit d);
    btn_set_i = s; btn_inc_i = i; btn_dec_i = d;
    tick(1);
    btn_set_i = 1'b0; btn_inc_i = 1'b0; btn_dec_i = 1'b0;
    tick(1);
  endtask

  task automatic press_n(input bit i, input bit d, input int n);
    for (int k = 0; k < n; k++) press(1'b0, i, d);
  endtask

  task automatic expect_out(input string nm, input int h, input int m, input int s,
                            input int ed, input int fld, input int bl, input int ld);
    snap_t e;
    e.name    = nm;
    e.h       = 5'(h);
    e.m       = 6'(m);
    e.s       = 6'(s);
    e.ed      = 1'(ed);
    e.fld     = 2'(fld);
    e.bl      = (bl < 0) ? 1'b0 : 1'(bl);
    e.bl_care = (bl >= 0);
    e.ld      = 1'(ld);
    snap_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic expect_load(input int h, input int m, input int s);
    load_t l;
    l.h = 5'(h); l.m = 6'(m); l.s = 6'(s);
    load_q.push_back(l);
  endtask

  initial begin
    reset_i = 1'b1;
    btn_set_i = 1'b0; btn_inc_i = 1'b0; btn_dec_i = 1'b0;
    cur_hrs_i = 5'd17; cur_min_i = 6'd35; cur_sec_i = 6'd42;
    tick(2);
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    tick(2);

    // Entry capture, hour wrap
    press(1, 0, 0);
    expect_out("enter_capture", 17, 35, 42, 1, 1, 1, 0);
    press_n(1, 0, 6);
    expect_out("hrs_23", 23, 35, 42, 1, 1, 1, 0);
    press_n(1, 0, 1);
    expect_out("hrs_wrap_0", 0, 35, 42, 1, 1, 1, 0);

    // Minutes: to 0 then dec wraps to 59
    press(1, 0, 0);
    expect_out("min_entry", 0, 35, 42, 1, 2, 1, 0);
    press_n(1, 0, 25);
    expect_out("min_0", 0, 0, 42, 1, 2, 1, 0);
    press_n(0, 1, 1);
    expect_out("min_dec_wrap", 0, 59, 42, 1, 2, 1, 0);

    // Set with inc in the same cycle advances only
    press(1, 1, 0);
    expect_out("set_inc_same", 0, 59, 42, 1, 3, 1, 0);
    press_n(1, 0, 17);
    expect_out("sec_59", 0, 59, 59, 1, 3, 1, 0);
    press_n(1, 0, 1);
    expect_out("sec_inc_wrap", 0, 59, 0, 1, 3, 1, 0);
    press_n(1, 0, 10);
    expect_out("sec_10", 0, 59, 10, 1, 3, 1, 0);

    // Auto-repeat: 1000 held cycles give 6 steps; re-hold of 550 gives 2
    btn_inc_i = 1'b1;
    tick(1000);
    btn_inc_i = 1'b0;
    tick(2);
    expect_out("hold_1000", 0, 59, 16, 1, 3, 1, 0);
    btn_inc_i = 1'b1;
    tick(550);
    btn_inc_i = 1'b0;
    tick(2);
    expect_out("rehold_550", 0, 59, 18, 1, 3, 1, 0);

    // Blink restarts on a step and toggles every 250 cycles
    press_n(1, 0, 1);
    tick(260);
    expect_out("blink_off", 0, 59, 19, 1, 3, 0, 0);
    tick(250);
    expect_out("blink_on", 0, 59, 19, 1, 3, 1, 0);

    // Commit from SEC
    expect_load(0, 59, 19);
    press(1, 0, 0);
    expect_out("commit1", 0, 59, 19, 0, 0, 0, 1);
    expect_out("after_commit1", 0, 59, 19, 0, 0, 0, 0);
    press_n(1, 0, 1);
    expect_out("idle_inc_ignored", 0, 59, 19, 0, 0, 0, 0);

    // Full edit 17:35:42 -> 08:00:05
    press(1, 0, 0);
    expect_out("reenter", 17, 35, 42, 1, 1, 1, 0);
    press_n(0, 1, 9);
    press(1, 0, 0);
    press_n(1, 0, 25);
    press(1, 0, 0);
    press_n(1, 0, 23);
    expect_out("pre_commit", 8, 0, 5, 1, 3, 1, 0);
    expect_load(8, 0, 5);
    press(1, 0, 0);
    expect_out("commit2", 8, 0, 5, 0, 0, 0, 1);
    expect_out("after_commit2", 8, 0, 5, 0, 0, 0, 0);

    // Timeout without load
    press(1, 0, 0);
    tick(9990);
    expect_out("before_timeout", 17, 35, 42, 1, 1, -1, 0);
    tick(20);
    expect_out("timeout_idle", 17, 35, 42, 0, 0, 0, 0);

    // Reset mid-MIN
    press(1, 0, 0);
    press(1, 0, 0);
    expect_out("mid_min", 17, 35, 42, 1, 2, 1, 0);
    reset_i = 1'b1;
    #1;
    expect_out("reset_mid_edit", 0, 0, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    tick(2);
    expect_out("after_reset", 0, 0, 0, 0, 0, 0, 0);

    // Out-of-range capture, simultaneous inc/dec
    cur_hrs_i = 5'd30;
    press(1, 0, 0);
    expect_out("capture_30", 30, 35, 42, 1, 1, 1, 0);
    press(0, 1, 1);
    expect_out("inc_dec_both", 30, 35, 42, 1, 1, 1, 0);
    press_n(0, 1, 1);
    expect_out("dec_from_30", 23, 35, 42, 1, 1, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    expect_load(23, 35, 42);
    press(1, 0, 0);
    expect_out("commit3", 23, 35, 42, 0, 0, 0, 1);
    tick(2);
    press(1, 0, 0);
    expect_out("recapture_30", 30, 35, 42, 1, 1, 1, 0);
    press_n(1, 0, 1);
    expect_out("inc_from_30", 0, 35, 42, 1, 1, 1, 0);

    tick(5);
    total++;
    if (load_q.size() != 0) begin
      bad++;
      $display("FAIL missing_load got=%0d pending exp=0", load_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel sequencer that lets the user edit the preset time (hours/minutes/seconds) fed to the 12 h and 24 h digital clocks' Hourset/Minset/Secset inputs. It replaces the hard-coded set registers in the top level.
- Driven from the 1 kHz divided clock, using already-debounced button levels.
- Walks the fields with a state machine, applies inc/dec with wrap-around and auto-repeat, and issues a one-cycle load pulse on commit.
- Provides field-select and blink status to the VGA overlay.

Parameters:
- REPEAT_DELAY, 500: hold cycles before auto-repeat starts.
- REPEAT_RATE, 100: cycles between auto-repeat steps.
- TIMEOUT, 10000: idle cycles in an edit state before abort.
- BLINK_HALF, 250: cycles per blink half-period.

Ports:
- clk_i  in  1  1 kHz divided clock.
- reset_i  in  1  asynchronous, active-high reset.
- btn_set_i  in  1  debounced set/next-field level.
- btn_inc_i  in  1  debounced increment level.
- btn_dec_i  in  1  debounced decrement level.
- cur_hrs_i  in  5  running 24 h hours, captured on edit entry.
- cur_min_i  in  6  running minutes.
- cur_sec_i  in  6  running seconds.
- set_hrs_o  out  5  edited hours (shadow register).
- set_min_o  out  6  edited minutes.
- set_sec_o  out  6  edited seconds.
- load_o  out  1  one-cycle commit pulse to the clocks.
- editing_o  out  1  high in any edit state.
- field_o  out  2  0 = none, 1 = hrs, 2 = min, 3 = sec.
- blink_o  out  1  blink enable for the selected field.

Behaviour:
- One clock, clk_i. reset_i is asynchronous, active-high.
- Reset values:
  - state IDLE.
  - set_hrs_o = set_min_o = set_sec_o = 0.
  - load_o = 0, editing_o = 0, field_o = 0, blink_o = 0.
  - All counters 0; button edge-detect registers 0.
- Reset asserted mid-edit aborts immediately. Shadows clear to 0. No load pulse.
- Edges: each button input is registered once. rise = current & ~previous. All actions use rises, except the hold counters.
- States: IDLE, HRS, MIN, SEC, COMMIT.
- IDLE:
  - set rise → capture cur_*_i into the shadows, go to HRS.
  - inc/dec ignored.
- HRS → MIN → SEC on set rise.
- SEC + set rise → COMMIT.
- COMMIT:
  - Lasts exactly one cycle with load_o = 1, then IDLE.
  - load_o is high in the cycle after the set rise is registered.
- Shadows hold their values after commit. set_*_o always drive the shadows.
- Field step rules (selected field only):
  - inc: value >= MAX → 0, else +1.
  - dec: value == 0 or value > MAX → MAX, else −1.
  - MAX = 23 for hours, 59 for minutes and seconds.
  - Out-of-range captured values are therefore normalised by the first step.
- Simultaneous inc and dec rise: no step.
- Set rise in the same cycle as inc/dec rise: advance only; the step is dropped.
- Auto-repeat:
  - A hold counter runs while exactly one of inc/dec is high in an edit state.
  - It clears on release, on field change, or when both buttons are high.
  - Steps at the rise (count 0), then at count REPEAT_DELAY, then every REPEAT_RATE cycles after that.
  - Counter saturates; no overflow.
- Timeout:
  - The inactivity counter clears on any button rise or high level.
  - Reaching TIMEOUT in HRS/MIN/SEC → IDLE with no load. Shadows keep their edited values, but no pulse is issued.
- editing_o = 1 in HRS/MIN/SEC; 0 in IDLE/COMMIT.
- field_o follows the state (COMMIT = 0).
- Blink:
  - blink_o = 1 on entry to each field and after any step.
  - Toggles every BLINK_HALF cycles while editing.
  - Forced 0 in IDLE/COMMIT.
  - The blink counter restarts on field change or step, so the digit stays visible while adjusting.
- Latency: input level → registered edge → state/shadow update = 2 clk_i cycles from button change.

Test Plan:
- Reset then cur = 17:35:42; pulse set → field_o = 1, set_* = 17:35:42, blink_o = 1; pulse inc ×7 → set_hrs_o = 0 (wrap 23→0 after 6 steps).
- In MIN with value 0, pulse dec → 59; in SEC with value 59, pulse inc → 0; set_hrs_o unchanged throughout.
- Hold inc 1000 cycles in SEC starting from 10 → steps at 0, 500, 600, 700, 800, 900 → set_sec_o = 16; release then re-hold restarts the delay.
- Full edit 17:35:42 → 08:00:05, set ×3 → exactly one cycle load_o = 1 with outputs 08:00:05; next cycle editing_o = 0, field_o = 0.
- Enter edit, no buttons for 10000 cycles → IDLE, load_o never asserted; separately assert reset_i mid-MIN → immediate IDLE with outputs all 0.
- Inc and dec rising together → no change; cur_hrs_i = 30 captured, dec → 23, inc (from 30 on re-entry) → 0.
